// File: rtl/spiflash_reader.sv
// Single-SPI word reader: READ (0x03) + 24-bit address, 32 data bits in, little-endian word out.
// Optional power-up 0xAB release-from-deep-power-down sequence when SPIFLASH_WAKEUP_EN is defined.
module spiflash_reader #(
  parameter int CLK_DIV   = 1,
  parameter int WAKE_WAIT = 48
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [23:0] addr,
  output logic [31:0] rdata,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_mosi,
  input  logic        flash_miso
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SHIFT_OUT = 3'd1;
  localparam logic [2:0] ST_SHIFT_IN  = 3'd2;
  localparam logic [2:0] ST_DONE      = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;
`ifdef SPIFLASH_WAKEUP_EN
  localparam logic [2:0] ST_WAKE_CMD  = 3'd5;
  localparam logic [2:0] ST_WAKE_WAIT = 3'd6;
  localparam logic [2:0] ST_RESET     = ST_WAKE_CMD;
`else
  localparam logic [2:0] ST_RESET     = ST_IDLE;
`endif

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_MAX = (WAKE_WAIT > 2 * CLK_DIV) ? WAKE_WAIT : 2 * CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(2 * CLK_DIV - 2);
`ifdef SPIFLASH_WAKEUP_EN
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_WAIT - 1);
  localparam logic [31:0]      WAKE_WORD = 32'hAB00_0000;
`endif

  logic [2:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      tx_sreg;
  logic [31:0]      rx_sreg;
  logic [31:0]      cmd_word;
  logic             sck_run;
  logic             tick;

  // Low address bits are masked so every request fetches an aligned word.
  assign cmd_word = {8'h03, addr & 24'hFF_FFFC};

  always_comb begin
    sck_run = 1'b0;
    case (state)
      ST_SHIFT_OUT: sck_run = 1'b1;
      ST_SHIFT_IN:  sck_run = (bit_cnt != 6'd32);
`ifdef SPIFLASH_WAKEUP_EN
      ST_WAKE_CMD:  sck_run = !flash_csb;
`endif
      default:      sck_run = 1'b0;
    endcase
  end

  assign tick = sck_run && (div_cnt == DIV_LAST);

  // NOTE: every register below updates with <= so all of them see pre-edge values in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
    end else if (!sck_run || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_RESET;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      tx_sreg    <= '0;
      rx_sreg    <= '0;
      rdata      <= '0;
      ready      <= 1'b0;
      flash_csb  <= 1'b1;
      flash_clk  <= 1'b0;
      flash_mosi <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid) begin
            tx_sreg    <= cmd_word;
            flash_mosi <= cmd_word[31];
            flash_csb  <= 1'b0;
            flash_clk  <= 1'b0;
            bit_cnt    <= '0;
            state      <= ST_SHIFT_OUT;
          end
        end

        ST_SHIFT_OUT: begin
          if (tick) begin
            flash_clk <= ~flash_clk;
            // Mode 0: the flash samples on the rising edge, so new data moves on the falling one.
            if (flash_clk) begin
              if (bit_cnt == 6'd31) begin
                bit_cnt    <= '0;
                flash_mosi <= 1'b0;
                state      <= ST_SHIFT_IN;
              end else begin
                bit_cnt    <= bit_cnt + 6'd1;
                tx_sreg    <= tx_sreg << 1;
                flash_mosi <= tx_sreg[30];
              end
            end
          end
        end

        ST_SHIFT_IN: begin
          if (bit_cnt == 6'd32) begin
            state <= ST_DONE;
          end else if (tick) begin
            flash_clk <= ~flash_clk;
            if (!flash_clk) begin
              rx_sreg <= {rx_sreg[30:0], flash_miso};
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end

        ST_DONE: begin
          // First byte received sits in rx_sreg[31:24] and belongs in the low byte of the word.
          rdata     <= {rx_sreg[7:0], rx_sreg[15:8], rx_sreg[23:16], rx_sreg[31:24]};
          ready     <= 1'b1;
          flash_csb <= 1'b1;
          flash_clk <= 1'b0;
          wait_cnt  <= '0;
          state     <= ST_GAP;
        end

        ST_GAP: begin
          if (wait_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

`ifdef SPIFLASH_WAKEUP_EN
        ST_WAKE_CMD: begin
          if (flash_csb) begin
            tx_sreg    <= WAKE_WORD;
            flash_mosi <= WAKE_WORD[31];
            flash_csb  <= 1'b0;
            flash_clk  <= 1'b0;
            bit_cnt    <= '0;
          end else if (tick) begin
            flash_clk <= ~flash_clk;
            if (flash_clk) begin
              if (bit_cnt == 6'd7) begin
                flash_csb  <= 1'b1;
                flash_mosi <= 1'b0;
                wait_cnt   <= '0;
                state      <= ST_WAKE_WAIT;
              end else begin
                bit_cnt    <= bit_cnt + 6'd1;
                tx_sreg    <= tx_sreg << 1;
                flash_mosi <= tx_sreg[30];
              end
            end
          end
        end

        ST_WAKE_WAIT: begin
          if (wait_cnt == WAKE_LAST) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spiflash_reader.sv
// Bench for spiflash_reader: lane 0 runs CLK_DIV=1, lane 1 runs CLK_DIV=3, both against a bit-level flash model.
// Wake-up checks are compiled in when SPIFLASH_WAKEUP_EN is defined.
module tb_spiflash_reader;

  localparam int CLKP      = 10;
  localparam int WAKE_WAIT = 48;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  valid;
  logic [1:0]  ready;
  logic [1:0]  csb;
  logic [1:0]  sck;
  logic [1:0]  mosi;
  logic [1:0]  miso = 2'b00;
  logic [23:0] addr  [2];
  logic [31:0] rdata [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #(CLKP / 2) clk = ~clk;
  always @(posedge clk) cyc++;

  spiflash_reader #(.CLK_DIV(1), .WAKE_WAIT(WAKE_WAIT)) u_dut_div1 (
    .clk(clk), .resetn(resetn), .valid(valid[0]), .ready(ready[0]), .addr(addr[0]),
    .rdata(rdata[0]), .flash_csb(csb[0]), .flash_clk(sck[0]), .flash_mosi(mosi[0]),
    .flash_miso(miso[0])
  );

  spiflash_reader #(.CLK_DIV(3), .WAKE_WAIT(WAKE_WAIT)) u_dut_div3 (
    .clk(clk), .resetn(resetn), .valid(valid[1]), .ready(ready[1]), .addr(addr[1]),
    .rdata(rdata[1]), .flash_csb(csb[1]), .flash_clk(sck[1]), .flash_mosi(mosi[1]),
    .flash_miso(miso[1])
  );

  // Flash contents: explicit bytes where written, otherwise a fixed function of the address.
  logic [7:0] mem [int];

  function automatic logic [7:0] byte_at(input int a);
    if (mem.exists(a)) return mem[a];
    return 8'((a * 7) + 3);
  endfunction

  // Flash model state, sampled on the falling clk edge when DUT pins are stable.
  logic        prev_csb [2] = '{1'b1, 1'b1};
  logic        prev_sck [2] = '{1'b0, 1'b0};
  int          bitn     [2] = '{0, 0};
  logic [31:0] cmd_in   [2];
  logic [31:0] dout     [2];
  logic [31:0] seen_cmd [2];
  int          seen_bits[2] = '{0, 0};
  int          r0       [2] = '{0, 0};
  int          sck_period[2] = '{0, 0};
  int          mosi_err [2] = '{0, 0};
  int          ready_pulses[2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ready[i] === 1'b1) ready_pulses[i]++;
      if (csb[i] !== 1'b0) begin
        if (prev_csb[i] === 1'b0) begin
          seen_cmd[i]  = cmd_in[i];
          seen_bits[i] = bitn[i];
        end
        bitn[i] = 0;
      end else if (sck[i] === 1'b1 && prev_sck[i] === 1'b0) begin
        if (bitn[i] == 0) r0[i] = cyc;
        else if (bitn[i] == 1) sck_period[i] = cyc - r0[i];
        if (bitn[i] < 32) cmd_in[i] = {cmd_in[i][30:0], mosi[i]};
        else if (mosi[i] !== 1'b0) mosi_err[i]++;
        bitn[i]++;
        if (bitn[i] == 32) begin
          dout[i] = {byte_at(int'(cmd_in[i][23:0])),     byte_at(int'(cmd_in[i][23:0]) + 1),
                     byte_at(int'(cmd_in[i][23:0]) + 2), byte_at(int'(cmd_in[i][23:0]) + 3)};
        end
      end else if (sck[i] === 1'b0 && prev_sck[i] === 1'b1 && bitn[i] >= 32 && bitn[i] < 64) begin
        miso[i] = dout[i][63 - bitn[i]];
      end
      prev_csb[i] = csb[i];
      prev_sck[i] = sck[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns the number of clk edges after the caller's reference edge at which ready was seen high.
  task automatic wait_ready(input int i, output int cnt);
    cnt = 0;
    while (ready[i] !== 1'b1 && cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    int b;
    b = int'(a & 24'hFF_FFFC);
    return {byte_at(b + 3), byte_at(b + 2), byte_at(b + 1), byte_at(b)};
  endfunction

  task automatic do_read(input int i, input logic [23:0] a, input string tag);
    int d;
    int cnt;
    logic [31:0] expw;
    d    = (i == 0) ? 1 : 3;
    expw = exp_word(a);
    repeat (8) @(negedge clk);
    valid[i] = 1'b1;
    addr[i]  = a;
    @(posedge clk);
    #1;
    valid[i] = 1'b0;
    addr[i]  = 24'($urandom);
    wait_ready(i, cnt);
    check({tag, " latency"}, cnt, 128 * d + 2);
    check({tag, " rdata"}, rdata[i], expw);
    check({tag, " csb at ready"}, csb[i], 1'b1);
    @(posedge clk);
    #1;
    check({tag, " ready width"}, ready[i], 1'b0);
    check({tag, " cmd sent"}, seen_cmd[i], {8'h03, a & 24'hFF_FFFC});
    check({tag, " sck count"}, seen_bits[i], 64);
  endtask

  initial begin
    #(CLKP * 60000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int gap;
    int p0;
    int falls;
    logic prev;
    logic [23:0] ra;

    resetn   = 1'b0;
    valid    = 2'b00;
    addr[0]  = '0;
    addr[1]  = '0;
    mem[32'h100000] = 8'h13; mem[32'h100001] = 8'h00;
    mem[32'h100002] = 8'h00; mem[32'h100003] = 8'h00;
    mem[32'h100004] = 8'h93; mem[32'h100005] = 8'h00;
    mem[32'h100006] = 8'h10; mem[32'h100007] = 8'h00;

    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset csb lane%0d", i), csb[i], 1'b1);
      check($sformatf("reset sck lane%0d", i), sck[i], 1'b0);
      check($sformatf("reset mosi lane%0d", i), mosi[i], 1'b0);
      check($sformatf("reset ready lane%0d", i), ready[i], 1'b0);
      check($sformatf("reset rdata lane%0d", i), rdata[i], 32'h0);
    end

`ifdef SPIFLASH_WAKEUP_EN
    // Wake-up: valid from the first cycle must wait for 0xAB plus the WAKE_WAIT hold-off.
    valid[0] = 1'b1;
    addr[0]  = 24'h100000;
    resetn   = 1'b1;
    cnt = 0; falls = 0; prev = 1'b1;
    while (falls < 2 && cnt < 500) begin
      @(posedge clk);
      #1;
      cnt++;
      if (prev === 1'b1 && csb[0] === 1'b0) falls++;
      prev = csb[0];
    end
    valid[0] = 1'b0;
    check("wake accept cycle", cnt, 16 + 2 + WAKE_WAIT);
    check("wake cmd byte", seen_cmd[0][7:0], 8'hAB);
    check("wake cmd bits", seen_bits[0], 8);
    wait_ready(0, cnt);
    check("wake read latency", cnt, 130);
    check("wake read rdata", rdata[0], 32'h0000_0013);
    repeat (120) @(posedge clk);
`else
    @(negedge clk);
    resetn = 1'b1;
`endif

    do_read(0, 24'h100000, "read aligned");
    check("sck period div1", sck_period[0], 2);
    do_read(0, 24'h100006, "read unaligned");

    // Back-to-back with valid held: csb high exactly 2 clk between the two transactions.
    repeat (8) @(negedge clk);
    valid[0] = 1'b1;
    addr[0]  = 24'h100000;
    @(posedge clk);
    #1;
    addr[0] = 24'h100006;
    wait_ready(0, cnt);
    check("b2b first latency", cnt, 130);
    check("b2b first rdata", rdata[0], 32'h0000_0013);
    gap = 0;
    while (csb[0] === 1'b1 && gap < 50) begin
      @(posedge clk);
      #1;
      gap++;
    end
    valid[0] = 1'b0;
    check("b2b csb high clk", gap, 2);
    check("b2b first cmd", seen_cmd[0], 32'h0310_0000);
    wait_ready(0, cnt);
    check("b2b second latency", cnt, 130);
    check("b2b second rdata", rdata[0], 32'h0010_0093);
    @(posedge clk);
    #1;
    check("b2b second cmd", seen_cmd[0], 32'h0310_0004);

    do_read(1, 24'h100000, "div3 read");
    check("sck period div3", sck_period[1], 6);

    for (int k = 0; k < 6; k++) begin
      ra = 24'($urandom);
      for (int b = 0; b < 4; b++) mem[int'(ra & 24'hFF_FFFC) + b] = 8'($urandom);
      do_read(k % 3 == 2 ? 1 : 0, ra, $sformatf("random read %0d", k));
    end

    // Abort mid-SHIFT_IN: pins snap back at once and the aborted read never completes.
    repeat (8) @(negedge clk);
    valid[0] = 1'b1;
    addr[0]  = 24'h100004;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    p0     = ready_pulses[0];
    resetn = 1'b0;
    #1;
    check("abort csb", csb[0], 1'b1);
    check("abort sck", sck[0], 1'b0);
    check("abort mosi", mosi[0], 1'b0);
    check("abort ready", ready[0], 1'b0);
    check("abort rdata", rdata[0], 32'h0);
`ifdef SPIFLASH_WAKEUP_EN
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (250) @(posedge clk);
    #1;
    check("abort no ready", ready_pulses[0] - p0, 0);
    do_read(0, 24'h100004, "post-abort read");
`else
    // Valid already high when reset releases is taken on the first edge.
    ra = 24'($urandom);
    for (int b = 0; b < 4; b++) mem[int'(ra & 24'hFF_FFFC) + b] = 8'($urandom);
    valid[0] = 1'b1;
    addr[0]  = ra;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    wait_ready(0, cnt);
    check("release accept latency", cnt, 130);
    check("release accept rdata", rdata[0], exp_word(ra));
    @(posedge clk);
    #1;
    check("abort single ready", ready_pulses[0] - p0, 1);
    check("release accept cmd", seen_cmd[0], {8'h03, ra & 24'hFF_FFFC});
`endif

    check("mosi idle in data lane0", mosi_err[0], 0);
    check("mosi idle in data lane1", mosi_err[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spiflash_reader.md
Name: spiflash_reader

Overview:
- Single-SPI read controller between the core's instruction/data memory bus and the external SPI flash pins.
- Accepts a word-read request on a valid/ready bus, issues READ (0x03) plus a 24-bit address, shifts in 32 data bits and returns one little-endian word.
- Sits directly upstream of the flash pins on the hardware top; drives csb/clk/io0, samples io1. The top ties io2/io3 high (WP#/HOLD# inactive).

Parameters:
- CLK_DIV, 1: SCK half-period in clk cycles (>=1); SCK = clk/(2*CLK_DIV).
- WAKE_WAIT, 48: clk cycles waited after the wake command; used only with SPIFLASH_WAKEUP_EN.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- valid  in  1  read request; held until ready
- ready  out  1  one-cycle pulse; rdata valid in the same cycle
- addr  in  24  byte address; addr[1:0] ignored (forced 0)
- rdata  out  32  read word; first byte received lands in [7:0]
- flash_csb  out  1  chip select, active low
- flash_clk  out  1  SPI clock, mode 0 (idle low)
- flash_mosi  out  1  to flash io0
- flash_miso  in  1  from flash io1

Behaviour:
- Reset (resetn=0, async): flash_csb=1, flash_clk=0, flash_mosi=0, ready=0, rdata=0, bit counter=0, divider=0, state=IDLE (WAKE_CMD if macro).
- States: IDLE -> SHIFT_OUT (32 bits) -> SHIFT_IN (32 bits) -> DONE -> GAP -> IDLE.
- IDLE: on a clk edge with valid=1, latch {0x03, addr[23:2], 2'b00} into a 32-bit shift register, drive flash_csb=0, and drive flash_mosi = bit 31, all after that same edge.
- Divider tick every CLK_DIV clk. flash_clk toggles on each tick. On rising SCK, sample miso (only in SHIFT_IN). On falling SCK, shift next mosi bit out. MSB first.
- SHIFT_IN: bits assembled per byte MSB first. Byte n (n=0..3) goes to rdata[8n+7:8n].
- mosi is held 0 during SHIFT_IN.
- DONE: ready=1 for exactly one clk, flash_csb=1, flash_clk=0.
- Latency: ready is asserted exactly 128*CLK_DIV+2 clk edges after the accepting edge. This is 130 for CLK_DIV=1.
- GAP: flash_csb stays high for 2*CLK_DIV clk. valid is ignored until the block returns to IDLE.
- Minimum request-to-request period: 130*CLK_DIV+2 cycles.
- addr is latched at accept; changes mid-transaction have no effect.
- valid dropped mid-transaction: the transaction still completes and ready still pulses. The caller must not do this.
- rdata holds its last value until the next DONE.
- resetn asserted mid-transaction: immediate abort. Pins return to reset values; no ready pulse.
- valid high during reset release is accepted on the first clk edge in IDLE.

Optional Feature:
- Macro: SPIFLASH_WAKEUP_EN.
- Defined: after reset the block enters WAKE_CMD and shifts 0xAB (8 bits, same SCK timing).
- It then raises csb and waits WAKE_WAIT clk in WAKE_WAIT state, then enters IDLE.
- valid is ignored until IDLE; the first accept is no earlier than 16*CLK_DIV+2+WAKE_WAIT cycles after reset release.
- Not defined: reset goes straight to IDLE. No 0xAB is ever sent.

Test Plan:
- Reset: hold resetn=0 for 5 cycles -> csb=1, flash_clk=0, mosi=0, ready=0, rdata=0x00000000. Assert resetn mid-SHIFT_IN -> csb=1 within the same cycle, no ready.
- Read addr=0x100000, flash bytes 13 00 00 00 at 0x100000, CLK_DIV=1 -> mosi carries 0x03100000 over 32 SCK. ready pulses at cycle 130 after accept. rdata=0x00000013.
- Unaligned addr=0x100006, bytes at 0x100004 = 93 00 10 00 -> address sent is 0x100004, rdata=0x00100093.
- Back-to-back: valid held high across two requests -> csb high for exactly 2 clk between transactions. Both words are correct.
- CLK_DIV=3: same read as the first read scenario -> SCK period 6 clk, ready at cycle 386, same rdata.
- Build with SPIFLASH_WAKEUP_EN: after reset release, 0xAB is shifted and csb rises. valid is asserted at cycle 1 but not accepted until after WAKE_WAIT=48 cycles. The subsequent read returns correct data.
